mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Responder end of the FU↔MDU handshake. Owns the HI/LO registers, a multi-cycle multiplier and an iterative radix-2 divider.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO (HI/LO writers), MFHI/MFLO (readers) and SPECIAL2 MUL (GPR result, two-phase handshake).
- Sits beside the execute stage. The FU drives start/op/operands and stalls until mdu_recv.

Parameters:
- MUL_CYCLES, 2: cycles from accept to multiply product valid, range 1..4.
- DIV_CYCLES, 34: fixed divide latency (1 setup + 32 iterations + 1 sign fix). Informational only; not a legal override.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mdu_start  in  1  request valid this cycle
- mdu_started  in  1  FU's current MDU instruction was already accepted; it is waiting for a MUL result
- mdu_op  in  4  operation code (`MULT,`MULTU,`DIV,`DIVU,`MFHI,`MFLO,`MTHI,`MTLO,`MUL,`MADD,`MADDU,`MSUB,`MSUBU)
- mdu_srcA  in  32  rs operand
- mdu_srcB  in  32  rt operand
- mdu_recv  out  1  request accepted / result valid
- mdu_result  out  32  read data (MFHI/MFLO/MUL)
- mdu_busy  out  1  HI/LO update pending

Behaviour:
- States: IDLE, MUL_BUSY, DIV_BUSY, MULG_DONE.
- Reset: state=IDLE, HI=LO=0, counters=0, mdu_recv=0, mdu_result=0, mdu_busy=0. Reset mid-operation aborts the operation; HI/LO are not written.
- mdu_busy = (state != IDLE).
- MFHI/MFLO in IDLE:
  - mdu_recv=1 combinationally in the same cycle; mdu_result=HI or LO.
  - Repeated start of a read while the FU stalls returns the same value.
- MFHI/MFLO while busy: mdu_recv=0 until the cycle state returns to IDLE with the new HI/LO visible.
- MTHI/MTLO in IDLE: mdu_recv=1 same cycle; HI or LO ← srcA at the clock edge. When busy, held off like reads.
- MULT/MULTU in IDLE:
  - mdu_recv=1 (accept); operands latched; state→MUL_BUSY.
  - After MUL_CYCLES cycles, {HI,LO} ← 64-bit product (signed or unsigned); state→IDLE.
- DIV/DIVU in IDLE:
  - mdu_recv=1 (accept); state→DIV_BUSY; 34 cycles later LO ← quotient, HI ← remainder.
  - Remainder takes the sign of the dividend.
- MUL in IDLE:
  - Phase 1: mdu_recv=1 (accept); state→MUL_BUSY with the gpr flag set.
  - Phase 2: on completion, state→MULG_DONE, mdu_result ← low 32 bits, HI/LO unchanged.
  - MULG_DONE: mdu_recv=1 if mdu_started=1. Then state→IDLE.
  - If mdu_started=0 in MULG_DONE (FU flushed), the result is discarded silently and state→IDLE.
- A start of any op other than a read while busy: mdu_recv=0, no effect.
- Division boundaries:
  - Divide by zero (both signednesses): LO=32'hFFFF_FFFF, HI=srcA.
  - Signed 32'h8000_0000 / -1: LO=32'h8000_0000, HI=0.
- mdu_result is 0 whenever mdu_recv=0.
- Combinational path from mdu_start/mdu_op to mdu_recv exists only in IDLE.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are accepted like MULT. At completion, {HI,LO} ← {HI,LO} ± product (64-bit wrap), one extra cycle (MUL_CYCLES+1).
- Undefined: these ops are treated as no-ops. mdu_recv=1 immediately, HI/LO unchanged.

Decomposition:
- Shared package mdu_pkg: state enum, DIV0_LO/DIV0_HI constants, DIV_CYCLES.
- Op codes remain the existing InstrDefine.svh macros.
- One sub-module, mdu_divider: start, signed flag, dividend, divisor → done, quotient, remainder. It owns the iteration counter and sign fix-up.
- Multiplier stays inline as a MUL_CYCLES-deep shift register of the product.

Test Plan:
- MTHI 32'h1234_5678, then MFHI in IDLE → recv=1 same cycle as MFHI start, result 32'h1234_5678.
- MULT srcA=-2, srcB=3 → accept recv pulse. MFLO issued next cycle → recv low for MUL_CYCLES-1 cycles, then LO=32'hFFFF_FFFA; HI=32'hFFFF_FFFF.
- DIVU 100/7 → accept. MFHI issued at once stalls 34 cycles → HI=2; LO=14.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF → LO=32'h8000_0000, HI=0. DIVU 5/0 → LO=32'hFFFF_FFFF, HI=5.
- MUL 7×6 with HI=LO=1: accept pulse, then mdu_started held high → second recv pulse with result 42; HI/LO still 1. Repeat with mdu_started dropped before completion → no second pulse; state IDLE.
- Reset asserted mid-DIV → next cycle mdu_busy=0, HI=LO=0. With MDU_MADD_EN: HI=0, LO=32'hFFFF_FFFF, MADDU 1×1 → HI=1, LO=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types, op codes and constants for the multiply/divide unit
// Contents: FSM state enum, MDU op codes, divide boundary constants, 32x32->64 multiply helper.
package mdu_pkg;

    // Fixed divide latency: 1 setup + 32 iterations + 1 sign fix.
    localparam int DIV_CYCLES = 34;

    // Divide by zero: LO is all ones; HI returns the dividend unchanged.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MUL_BUSY  = 2'd1,
        ST_DIV_BUSY  = 2'd2,
        ST_MULG_DONE = 2'd3
    } mdu_state_e;

    // Full 64-bit product; sign-extending both operands gives the signed result.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - FU<->MDU request/response handshake bundle
// master: FU side (drives start/started/op/operands); slave: MDU side (drives recv/result/busy).
interface mdu_if;
    logic        mdu_start;
    logic        mdu_started;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_srcA;
    logic [31:0] mdu_srcB;
    logic        mdu_recv;
    logic [31:0] mdu_result;
    logic        mdu_busy;

    modport master (
        output mdu_start, mdu_started, mdu_op, mdu_srcA, mdu_srcB,
        input  mdu_recv, mdu_result, mdu_busy
    );

    modport slave (
        input  mdu_start, mdu_started, mdu_op, mdu_srcA, mdu_srcB,
        output mdu_recv, mdu_result, mdu_busy
    );
endinterface

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - iterative radix-2 restoring divider with sign fix-up
// Ports: clk, reset (sync, active-high), start_i, signed_i, dividend_i, divisor_i
//        -> done_o (one-cycle pulse), quotient_o, remainder_o (valid while done_o).
module mdu_divider
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    // cnt_q: 33..2 iterate, 1 = sign fix, 0 = idle.
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] den_q, den_d;
    logic [31:0] raw_q, raw_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        done_q, done_d;
    logic [32:0] trial;

    always_comb begin
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        den_d  = den_q;
        raw_d  = raw_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        done_d = 1'b0;
        // Bit 32 set means the shifted partial remainder is below the divisor.
        trial  = {rem_q, quo_q[31]} - {1'b0, den_q};
        if (start_i) begin
            quo_d  = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
            den_d  = (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
            raw_d  = dividend_i;
            qneg_d = signed_i && (dividend_i[31] ^ divisor_i[31]);
            rneg_d = signed_i && dividend_i[31];
            rem_d  = '0;
            cnt_d  = 6'd33;
        end else if (cnt_q > 6'd1) begin
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = {rem_q[30:0], quo_q[31]};
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - 6'd1;
        end else if (cnt_q == 6'd1) begin
            // 0x8000_0000 / -1 needs no special case: |q| = 0x8000_0000 and
            // both signs cancel, so the magnitude is already the answer.
            if (den_q == '0) begin
                quo_d = DIV0_LO;
                rem_d = raw_q;
            end else begin
                quo_d = qneg_q ? -quo_q : quo_q;
                rem_d = rneg_q ? -rem_q : rem_q;
            end
            done_d = 1'b1;
            cnt_d  = 6'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            raw_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            raw_q  <= raw_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            done_q <= done_d;
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - MDU responder: HI/LO registers, pipelined multiplier, iterative divider
// Ports: clk, reset (sync, active-high), bus (mdu_if.slave: start/started/op/srcA/srcB in,
//        recv/result/busy out). Parameter MUL_CYCLES (1..4). Optional macro: MDU_MADD_EN.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    localparam logic [2:0] MUL_LAT  = 3'(MUL_CYCLES - 1);
    localparam logic [2:0] MADD_LAT = 3'(MUL_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gpr_q, gpr_d;
    logic        acc_q, acc_d;
    logic        sub_q, sub_d;
    logic [31:0] mulg_q, mulg_d;

    logic        recv;
    logic [31:0] result;
    logic        op_signed;
    logic [63:0] product;
    logic [63:0] acc_sum;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    mdu_divider u_div (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start),
        .signed_i    (bus.mdu_op == OP_DIV),
        .dividend_i  (bus.mdu_srcA),
        .divisor_i   (bus.mdu_srcB),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        gpr_d     = gpr_q;
        acc_d     = acc_q;
        sub_d     = sub_q;
        mulg_d    = mulg_q;
        recv      = 1'b0;
        result    = '0;
        div_start = 1'b0;
        op_signed = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MUL) ||
                    (bus.mdu_op == OP_MADD) || (bus.mdu_op == OP_MSUB);
        product   = mul64(bus.mdu_srcA, bus.mdu_srcB, op_signed);
        acc_sum   = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);

        unique case (state_q)
            // Only state with a combinational start->recv path. Unknown and
            // disabled ops are acknowledged so the FU never deadlocks.
            ST_IDLE: begin
                if (bus.mdu_start) begin
                    recv = 1'b1;
                    case (bus.mdu_op)
                        OP_MFHI: result = hi_q;
                        OP_MFLO: result = lo_q;
                        OP_MTHI: hi_d = bus.mdu_srcA;
                        OP_MTLO: lo_d = bus.mdu_srcA;
                        OP_MULT, OP_MULTU, OP_MUL: begin
                            prod_d = product;
                            gpr_d  = (bus.mdu_op == OP_MUL);
                            acc_d  = 1'b0;
                            sub_d  = 1'b0;
                            // Single-cycle multiply finishes on the accept edge.
                            if (MUL_CYCLES == 1) begin
                                if (bus.mdu_op == OP_MUL) begin
                                    mulg_d  = product[31:0];
                                    state_d = ST_MULG_DONE;
                                end else begin
                                    {hi_d, lo_d} = product;
                                end
                            end else begin
                                cnt_d   = MUL_LAT;
                                state_d = ST_MUL_BUSY;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            prod_d  = product;
                            gpr_d   = 1'b0;
                            acc_d   = 1'b1;
                            sub_d   = (bus.mdu_op == OP_MSUB) || (bus.mdu_op == OP_MSUBU);
                            cnt_d   = MADD_LAT;
                            state_d = ST_MUL_BUSY;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            div_start = 1'b1;
                            state_d   = ST_DIV_BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_BUSY: begin
                if (cnt_q <= 3'd1) begin
                    if (gpr_q) begin
                        mulg_d  = prod_q[31:0];
                        state_d = ST_MULG_DONE;
                    end else begin
                        {hi_d, lo_d} = acc_q ? acc_sum : prod_q;
                        state_d      = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DIV_BUSY: begin
                if (div_done) begin
                    lo_d    = div_quo;
                    hi_d    = div_rem;
                    state_d = ST_IDLE;
                end
            end
            ST_MULG_DONE: begin
                // FU no longer waiting (flushed) -> drop the result silently.
                if (bus.mdu_started) begin
                    recv   = 1'b1;
                    result = mulg_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            gpr_q   <= 1'b0;
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
            mulg_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            gpr_q   <= gpr_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            mulg_q  <= mulg_d;
        end
    end

    assign bus.mdu_recv   = recv;
    assign bus.mdu_result = result;
    assign bus.mdu_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - self-checking scoreboard bench for mdu_unit
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MUL_CYCLES = 2;
    localparam int LIMIT      = 200;
`ifdef MDU_MADD_EN
    localparam int MADD_STALL = MUL_CYCLES;
`else
    localparam int MADD_STALL = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if bus();

    mdu_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] hi_m, lo_m;
    logic [31:0] exp_q[$];
    int          stall;
    logic [31:0] got;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at posedge+1, holds start until recv is seen at a negedge, ends at posedge+1.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int st, output logic [31:0] res);
        bus.mdu_start = 1'b1;
        bus.mdu_op    = op;
        bus.mdu_srcA  = a;
        bus.mdu_srcB  = b;
        st  = 0;
        res = '0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (bus.mdu_recv === 1'b1) begin
                res = bus.mdu_result;
                break;
            end
            check_eq("result_zero_without_recv", bus.mdu_result, 32'h0);
            st++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.mdu_start = 1'b0;
    endtask

    task automatic read_hilo(input logic [3:0] op, input int exp_stall, input string tag);
        logic [31:0] e;
        exp_q.push_back(op == OP_MFHI ? hi_m : lo_m);
        run_op(op, 32'h0, 32'h0, stall, got);
        check_eq({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        e = exp_q.pop_front();
        if (stall < LIMIT) check_eq(tag, got, e);
    endtask

    task automatic write_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_MTHI: hi_m = a;
            OP_MTLO: lo_m = a;
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {hi_m, lo_m} = p;
            end
            OP_MULTU: {hi_m, lo_m} = {32'h0, a} * {32'h0, b};
            OP_DIV, OP_DIVU: begin
                if (b == 32'h0) begin
                    lo_m = 32'hFFFF_FFFF;
                    hi_m = a;
                end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000;
                    hi_m = 32'h0;
                end else if (op == OP_DIV) begin
                    lo_m = sa / sb;
                    hi_m = sa % sb;
                end else begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {hi_m, lo_m} = (op == OP_MADD) ? {hi_m, lo_m} + p : {hi_m, lo_m} - p;
            end
            OP_MADDU, OP_MSUBU: begin
                p = {32'h0, a} * {32'h0, b};
                {hi_m, lo_m} = (op == OP_MADDU) ? {hi_m, lo_m} + p : {hi_m, lo_m} - p;
            end
`endif
            default: ;
        endcase
        run_op(op, a, b, stall, got);
        check_eq({tag, "_accept_stall"}, 32'(stall), 32'h0);
    endtask

    // SPECIAL2 MUL: accept pulse, then optional second pulse carrying the GPR result.
    task automatic mul_gpr(input logic hold, input string tag);
        int pulses, first_at;
        logic [31:0] e;
        pulses   = 0;
        first_at = -1;
        bus.mdu_start   = 1'b1;
        bus.mdu_op      = OP_MUL;
        bus.mdu_srcA    = 32'd7;
        bus.mdu_srcB    = 32'd6;
        bus.mdu_started = 1'b0;
        @(negedge clk);
        check_eq({tag, "_accept"}, {31'h0, bus.mdu_recv}, 32'h1);
        @(posedge clk);
        #1;
        bus.mdu_start   = 1'b0;
        bus.mdu_started = hold;
        if (hold) exp_q.push_back(32'd42);
        for (int i = 0; i < MUL_CYCLES + 3; i++) begin
            @(negedge clk);
            if (bus.mdu_recv === 1'b1) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = i;
                    e = exp_q.pop_front();
                    check_eq({tag, "_result"}, bus.mdu_result, e);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.mdu_started = 1'b0;
        if (hold) begin
            check_eq({tag, "_pulses"}, 32'(pulses), 32'h1);
            check_eq({tag, "_result_delay"}, 32'(first_at), 32'(MUL_CYCLES - 1));
            if (first_at < 0) e = exp_q.pop_front();
        end else begin
            check_eq({tag, "_pulses"}, 32'(pulses), 32'h0);
        end
        @(negedge clk);
        check_eq({tag, "_busy_after"}, {31'h0, bus.mdu_busy}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mdu_start   = 1'b0;
        bus.mdu_started = 1'b0;
        bus.mdu_op      = 4'h0;
        bus.mdu_srcA    = '0;
        bus.mdu_srcB    = '0;
        reset           = 1'b1;
        hi_m            = '0;
        lo_m            = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_busy", {31'h0, bus.mdu_busy}, 32'h0);
        check_eq("reset_recv", {31'h0, bus.mdu_recv}, 32'h0);
        check_eq("reset_result", bus.mdu_result, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        read_hilo(OP_MFHI, 0, "reset_hi");
        read_hilo(OP_MFLO, 0, "reset_lo");

        write_op(OP_MTHI, 32'h1234_5678, 32'h0, "mthi");
        read_hilo(OP_MFHI, 0, "mfhi_after_mthi");
        read_hilo(OP_MFHI, 0, "mfhi_repeat");

        write_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult");
        read_hilo(OP_MFLO, MUL_CYCLES - 1, "mult_lo");
        read_hilo(OP_MFHI, 0, "mult_hi");

        write_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        read_hilo(OP_MFLO, MUL_CYCLES - 1, "multu_lo");
        read_hilo(OP_MFHI, 0, "multu_hi");

        write_op(OP_DIVU, 32'd100, 32'd7, "divu");
        read_hilo(OP_MFHI, 34, "divu_hi");
        read_hilo(OP_MFLO, 0, "divu_lo");

        write_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        read_hilo(OP_MFLO, 34, "div_neg_lo");
        read_hilo(OP_MFHI, 0, "div_neg_hi");

        write_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        read_hilo(OP_MFLO, 34, "div_ovf_lo");
        read_hilo(OP_MFHI, 0, "div_ovf_hi");

        write_op(OP_DIVU, 32'd5, 32'd0, "divu_zero");
        read_hilo(OP_MFLO, 34, "divu_zero_lo");
        read_hilo(OP_MFHI, 0, "divu_zero_hi");

        write_op(OP_DIV, 32'hFFFF_FFF7, 32'd0, "div_zero");
        read_hilo(OP_MFLO, 34, "div_zero_lo");
        read_hilo(OP_MFHI, 0, "div_zero_hi");

        // A writer presented while busy must be ignored.
        write_op(OP_DIVU, 32'd9, 32'd3, "divu_busy");
        bus.mdu_start = 1'b1;
        bus.mdu_op    = OP_MTHI;
        bus.mdu_srcA  = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("busy_write_recv", {31'h0, bus.mdu_recv}, 32'h0);
        check_eq("busy_flag", {31'h0, bus.mdu_busy}, 32'h1);
        @(posedge clk);
        #1;
        bus.mdu_start = 1'b0;
        read_hilo(OP_MFHI, 33, "busy_write_hi");
        read_hilo(OP_MFLO, 0, "busy_write_lo");

        write_op(OP_MTHI, 32'd1, 32'h0, "mthi_one");
        write_op(OP_MTLO, 32'd1, 32'h0, "mtlo_one");
        mul_gpr(1'b1, "mul_held");
        read_hilo(OP_MFHI, 0, "mul_hi_kept");
        read_hilo(OP_MFLO, 0, "mul_lo_kept");
        mul_gpr(1'b0, "mul_flushed");
        read_hilo(OP_MFLO, 0, "mul_flushed_lo");

        run_op(OP_DIVU, 32'd50, 32'd3, stall, got);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_mid_div_busy", {31'h0, bus.mdu_busy}, 32'h0);
        @(posedge clk);
        #1;
        hi_m = '0;
        lo_m = '0;
        read_hilo(OP_MFHI, 0, "reset_mid_div_hi");
        read_hilo(OP_MFLO, 0, "reset_mid_div_lo");

        write_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, "mtlo_ones");
        write_op(OP_MADDU, 32'd1, 32'd1, "maddu");
        read_hilo(OP_MFHI, MADD_STALL, "maddu_hi");
        read_hilo(OP_MFLO, 0, "maddu_lo");
        write_op(OP_MSUB, 32'd2, 32'd3, "msub");
        read_hilo(OP_MFLO, MADD_STALL, "msub_lo");
        read_hilo(OP_MFHI, 0, "msub_hi");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
